mult_div_unit: RTL and testbench

Execute-stage multiply/divide responder for the pipelined MIPS core. It consumes the decoder's mult/div/mfhi/mflo/mthi/mtlo control strobes and operands, models the fixed multi-cycle mult/div latency with a busy counter, and owns the HI/LO registers. The hazard unit stalls D-stage mult/div/HI-LO instructions while `start || busy`.

---
 rtl/mult_div_unit.sv | 121 ++++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO and models the fixed
// multi-cycle mult/div latency with a down-counter. It stalls the pipeline through busy.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic        isMU,
  input  logic        isDI,
  input  logic        isSigned,
  input  logic        WriteHL,
  input  logic        WriteHi,
  input  logic        ReadHi,
  output logic        busy,
  output logic [31:0] HLOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {OP_MUL, OP_DIV} op_e;

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             signed_q, signed_d;
  op_e              op_q, op_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [63:0] a_ext, b_ext, product;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
  logic        launch;

  // Result datapath works only from latched operands, so A/B may change while busy.
  always_comb begin
    a_ext   = signed_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext   = signed_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    product = a_ext * b_ext;
    a_neg   = signed_q & a_q[31];
    b_neg   = signed_q & b_q[31];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    divisor = (b_q == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
  end

  assign launch = start & ~busy_q & (isMU ^ isDI);

  // NOTE: every next-state signal gets a default first so this block never infers a latch.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    op_d     = op_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (op_q == OP_MUL) begin
          {hi_d, lo_d} = product;
        end else if (b_q != 32'd0) begin
          hi_d = rem;
          lo_d = quot;
        end
      end
    end else if (launch) begin
      a_d      = A;
      b_d      = B;
      signed_d = isSigned;
      op_d     = isMU ? OP_MUL : OP_DIV;
      busy_d   = 1'b1;
      cnt_d    = isMU ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (WriteHL && !start) begin
      if (WriteHi) hi_d = A;
      else         lo_d = A;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      op_q     <= OP_MUL;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign HLOut = ReadHi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: latency, HI/LO results, hazards
// and reset, with expected values computed by hand.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic        start, isMU, isDI, isSigned, WriteHL, WriteHi, ReadHi;
  logic        busy;
  logic [31:0] HLOut, HI, LO;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi, m_lo;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .start(start), .isMU(isMU),
    .isDI(isDI), .isSigned(isSigned), .WriteHL(WriteHL), .WriteHi(WriteHi),
    .ReadHi(ReadHi), .busy(busy), .HLOut(HLOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; A = '0; B = '0; start = 0; isMU = 0; isDI = 0; isSigned = 0;
    WriteHL = 0; WriteHi = 0; ReadHi = 0;
    #12;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", HI); end
    n_tests++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", LO); end
    #1 reset = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", busy); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic do_mt(input logic hi, input logic [31:0] val);
    WriteHL = 1; WriteHi = hi; A = val;
    tick();
    WriteHL = 0;
    if (hi) m_hi = val; else m_lo = val;
    ReadHi = hi;
    #1;
    n_tests++; if (HI !== m_hi || LO !== m_lo) begin
      n_fail++; $display("FAIL mt_regs got HI=%h LO=%h want HI=%h LO=%h", HI, LO, m_hi, m_lo); end
    n_tests++; if (HLOut !== val) begin n_fail++; $display("FAIL mt_hlout got %h want %h", HLOut, val); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mt_busy got %b want 0", busy); end
  endtask

  // mode: 0 plain, 1 start+WriteHL pulsed during busy, 2 WriteHL together with start
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic mu, input logic di, input logic sg, input int n,
                        input int mode, input logic [31:0] ehi, input logic [31:0] elo);
    A = a; B = b; isMU = mu; isDI = di; isSigned = sg; start = 1;
    if (mode == 2) begin WriteHL = 1; WriteHi = 1; end
    tick();
    start = 0; WriteHL = 0; isMU = 0; isDI = 0;
    A = ~a; B = 32'd0;
    for (int k = 1; k <= n; k++) begin
      if (mode == 1 && k == 2) begin
        start = 1; isDI = 1; WriteHL = 1; WriteHi = 1; A = 32'h0000DEAD; B = 32'd3;
      end
      if (mode == 1 && k == 3) begin
        start = 0; isDI = 0; WriteHL = 0;
      end
      #1;
      n_tests++; if (busy !== 1'b1) begin
        n_fail++; $display("FAIL %s busy_cycle%0d got %b want 1", nm, k, busy); end
      if (k == 1 || k == n) begin
        n_tests++; if (HI !== m_hi || LO !== m_lo) begin
          n_fail++; $display("FAIL %s hold_cycle%0d got HI=%h LO=%h want HI=%h LO=%h",
                             nm, k, HI, LO, m_hi, m_lo); end
        ReadHi = (k == n); #1;
        n_tests++; if (HLOut !== (ReadHi ? m_hi : m_lo)) begin
          n_fail++; $display("FAIL %s hlout_cycle%0d got %h want %h", nm, k, HLOut,
                             ReadHi ? m_hi : m_lo); end
      end
      tick();
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s done_busy got %b want 0", nm, busy); end
    n_tests++; if (HI !== ehi) begin n_fail++; $display("FAIL %s hi got %h want %h", nm, HI, ehi); end
    n_tests++; if (LO !== elo) begin n_fail++; $display("FAIL %s lo got %h want %h", nm, LO, elo); end
    m_hi = ehi; m_lo = elo;
  endtask

  task automatic test_mthi_mtlo();
    do_mt(1'b1, 32'h0000ABCD);
    do_mt(1'b0, 32'h00001234);
  endtask

  task automatic test_mult();
    run_op("mult_s", 32'hFFFFFFFE, 32'h3, 1, 0, 1, MULT_N, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 32'hFFFFFFFE, 32'h3, 1, 0, 0, MULT_N, 0, 32'h00000002, 32'hFFFFFFFA);
  endtask

  task automatic test_div();
    run_op("div_s", 32'hFFFFFFF9, 32'h2, 0, 1, 1, DIV_N, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 32'h7, 32'h2, 0, 1, 0, DIV_N, 0, 32'h1, 32'h3);
    run_op("div_ovf", 32'h80000000, 32'hFFFFFFFF, 0, 1, 1, DIV_N, 0, 32'h0, 32'h80000000);
  endtask

  task automatic test_div_by_zero();
    do_mt(1'b1, 32'h1111);
    do_mt(1'b0, 32'h2222);
    run_op("div0", 32'h5, 32'h0, 0, 1, 0, DIV_N, 0, 32'h1111, 32'h2222);
  endtask

  task automatic test_busy_hazards();
    run_op("hazard", 32'd6, 32'd7, 1, 0, 0, MULT_N, 1, 32'd0, 32'd42);
  endtask

  task automatic test_start_and_mt();
    do_mt(1'b1, 32'h5555);
    run_op("start_mt", 32'd3, 32'd4, 1, 0, 0, MULT_N, 2, 32'd0, 32'd12);
  endtask

  task automatic test_noop_start();
    for (int v = 0; v < 2; v++) begin
      A = 32'd9; B = 32'd9; isMU = (v == 1); isDI = (v == 1); start = 1;
      tick();
      start = 0; isMU = 0; isDI = 0;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noop%0d busy got %b want 0", v, busy); end
      tick();
      n_tests++; if (HI !== m_hi || LO !== m_lo) begin
        n_fail++; $display("FAIL noop%0d regs got HI=%h LO=%h want HI=%h LO=%h", v, HI, LO, m_hi, m_lo); end
    end
  endtask

  task automatic test_reset_mid_op();
    do_mt(1'b1, 32'h77);
    A = 32'd100; B = 32'd7; isDI = 1; start = 1;
    tick();
    start = 0; isDI = 0;
    for (int k = 1; k < 4; k++) tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid pre_busy got %b want 1", busy); end
    #1 reset = 1'b1;
    #1;
    ReadHi = 1'b1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy got %b want 0", busy); end
    n_tests++; if (HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid regs got HI=%h LO=%h want 0 0", HI, LO); end
    #1 reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    tick();
    n_tests++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid after got busy=%b HI=%h LO=%h want 0 0 0", busy, HI, LO); end
    run_op("post_rst", 32'd2, 32'd3, 1, 0, 0, MULT_N, 0, 32'd0, 32'd6);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mul", 32'h00010000, 32'h00010000, 1, 0, 0, MULT_N, 0, 32'h1, 32'h0);
    run_op("b2b_div", 32'hFFFFFFF9, 32'hFFFFFFFE, 0, 1, 1, DIV_N, 0, 32'hFFFFFFFF, 32'h3);
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_by_zero();
    test_busy_hazards();
    test_start_and_mt();
    test_noop_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
